// File: rtl/lcd_write_scheduler.sv
// Two-requester LCD byte scheduler: a small FIFO per requester, drained
// round-robin into the LCD writer's write_Enabled/iData/ready handshake.
`timescale 1ns/1ps
module lcd_write_scheduler #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iReq0Valid,
    input  logic [DATA_W-1:0] iReq0Data,
    output logic              oReq0Full,
    input  logic              iReq1Valid,
    input  logic [DATA_W-1:0] iReq1Data,
    output logic              oReq1Full,
    input  logic              iLcdInitialized,
    input  logic              iLcdReady,
    output logic              oLcdWrite,
    output logic [DATA_W-1:0] oLcdData,
    output logic              oBusy,
    output logic [1:0]        oGrant,
    output logic [1:0]        oOverflow
);

    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_ISSUE       = 2'd1,
        ST_WAIT_ACCEPT = 2'd2,
        ST_WAIT_DONE   = 2'd3
    } state_t;

    logic [DATA_W-1:0] mem_q     [2][DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q  [2];
    logic [ADDR_W-1:0] wr_ptr_d  [2];
    logic [ADDR_W-1:0] rd_ptr_q  [2];
    logic [ADDR_W-1:0] rd_ptr_d  [2];
    logic [CNT_W-1:0]  count_q   [2];
    logic [CNT_W-1:0]  count_d   [2];
    logic [1:0]        overflow_q;
    logic [1:0]        overflow_d;

    state_t            state_q;
    logic              prio_q;
    logic              lcd_write_q;
    logic [DATA_W-1:0] lcd_data_q;
    logic [1:0]        grant_q;
    logic              busy_q;

    logic [1:0]        valid_s;
    logic [DATA_W-1:0] wdata_s   [2];
    logic [1:0]        full_s;
    logic [1:0]        nonempty_s;
    logic [1:0]        push_s;
    logic [1:0]        pop_s;
    logic              start_s;
    logic              sel_s;

    // Full/empty come from the registered count so a same-cycle pop never frees a slot early
    always_comb begin
        valid_s    = {iReq1Valid, iReq0Valid};
        wdata_s[0] = iReq0Data;
        wdata_s[1] = iReq1Data;
        for (int n = 0; n < 2; n++) begin
            full_s[n]     = (count_q[n] == CNT_W'(DEPTH));
            nonempty_s[n] = (count_q[n] != CNT_W'(0));
            push_s[n]     = valid_s[n] & ~full_s[n];
        end
        start_s = (state_q == ST_IDLE) & iLcdInitialized & iLcdReady & (|nonempty_s);
        if (&nonempty_s) begin
            sel_s = prio_q;
        end else begin
            sel_s = nonempty_s[1];
        end
        pop_s = 2'b00;
        if (start_s) begin
            pop_s[sel_s] = 1'b1;
        end else begin
            pop_s = 2'b00;
        end
    end

    // FIFO pointer, count and sticky overflow next-state
    always_comb begin
        overflow_d = overflow_q;
        for (int n = 0; n < 2; n++) begin
            wr_ptr_d[n] = push_s[n] ? wr_ptr_q[n] + ADDR_W'(1) : wr_ptr_q[n];
            rd_ptr_d[n] = pop_s[n]  ? rd_ptr_q[n] + ADDR_W'(1) : rd_ptr_q[n];
            case ({push_s[n], pop_s[n]})
                2'b10:   count_d[n] = count_q[n] + CNT_W'(1);
                2'b01:   count_d[n] = count_q[n] - CNT_W'(1);
                default: count_d[n] = count_q[n];
            endcase
            if (valid_s[n] && full_s[n]) begin
                overflow_d[n] = 1'b1;
            end else begin
                overflow_d[n] = overflow_q[n];
            end
        end
    end

    // FIFO state registers; storage itself needs no reset since count gates every read
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int n = 0; n < 2; n++) begin
                wr_ptr_q[n] <= '0;
                rd_ptr_q[n] <= '0;
                count_q[n]  <= '0;
            end
            overflow_q <= 2'b00;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (push_s[n]) begin
                    mem_q[n][wr_ptr_q[n]] <= wdata_s[n];
                end
                wr_ptr_q[n] <= wr_ptr_d[n];
                rd_ptr_q[n] <= rd_ptr_d[n];
                count_q[n]  <= count_d[n];
            end
            overflow_q <= overflow_d;
        end
    end

    // Transaction FSM with registered handshake outputs and round-robin priority
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            prio_q      <= 1'b0;
            lcd_write_q <= 1'b0;
            lcd_data_q  <= '0;
            grant_q     <= 2'b00;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        lcd_data_q  <= mem_q[sel_s][rd_ptr_q[sel_s]];
                        grant_q     <= sel_s ? 2'b10 : 2'b01;
                        lcd_write_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ISSUE;
                        if (&nonempty_s) begin
                            prio_q <= ~sel_s;
                        end
                    end
                end
                ST_ISSUE: begin
                    lcd_write_q <= 1'b0;
                    state_q     <= ST_WAIT_ACCEPT;
                end
                ST_WAIT_ACCEPT: begin
                    if (!iLcdReady) begin
                        state_q <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (iLcdReady) begin
                        grant_q <= 2'b00;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    lcd_write_q <= 1'b0;
                    grant_q     <= 2'b00;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign oReq0Full = full_s[0];
    assign oReq1Full = full_s[1];
    assign oLcdWrite = lcd_write_q;
    assign oLcdData  = lcd_data_q;
    assign oBusy     = busy_q;
    assign oGrant    = grant_q;
    assign oOverflow = overflow_q;

endmodule
